// File: rtl/alu_operand_forward_unit_pkg.sv
// Shared types and constants for the EX-stage operand forwarding unit.
package alu_operand_forward_unit_pkg;

  localparam int DATA_W = 16;
  localparam int REG_AW = 3;
  localparam int CNT_W  = 16;

  // Shadow copy of one pipeline stage's destination bookkeeping.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              wr_en;
    logic              is_load;
  } stage_tag_t;

  typedef enum logic [1:0] {
    FWD_RF,
    FWD_EX,
    FWD_MEM,
    FWD_WB
  } fwd_src_e;

  // A stage can supply register r only if it will really write it; r0 is never forwarded.
  function automatic logic tag_match(stage_tag_t t, logic [REG_AW-1:0] r);
    return t.valid & t.wr_en & (t.rd == r) & (r != '0);
  endfunction

endpackage

// File: rtl/alu_operand_forward_unit_if.sv
// Decode-side inputs and EX-side outputs of the operand forwarding unit.
interface alu_operand_forward_unit_if;
  import alu_operand_forward_unit_pkg::*;

  logic              id_valid;
  logic [REG_AW-1:0] id_rs_a;
  logic [REG_AW-1:0] id_rs_b;
  logic              id_uses_a;
  logic              id_uses_b;
  logic [REG_AW-1:0] id_rd;
  logic              id_wr_en;
  logic              id_is_load;
  logic              id_use_imm;
  logic [DATA_W-1:0] rf_data_a;
  logic [DATA_W-1:0] rf_data_b;
  logic [DATA_W-1:0] ex_result;
  logic [DATA_W-1:0] mem_load_data;

  logic              stall;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_op_a;
  logic [DATA_W-1:0] ex_op_b;
  logic              ex_y_sel;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output id_valid, id_rs_a, id_rs_b, id_uses_a, id_uses_b, id_rd,
           id_wr_en, id_is_load, id_use_imm, rf_data_a, rf_data_b,
           ex_result, mem_load_data,
    input  stall, ex_valid, ex_op_a, ex_op_b, ex_y_sel, stall_count
  );

  modport slave (
    input  id_valid, id_rs_a, id_rs_b, id_uses_a, id_uses_b, id_rd,
           id_wr_en, id_is_load, id_use_imm, rf_data_a, rf_data_b,
           ex_result, mem_load_data,
    output stall, ex_valid, ex_op_a, ex_op_b, ex_y_sel, stall_count
  );

endinterface

// File: rtl/alu_operand_forward_unit_operand_fwd_select.sv
// Resolves one source operand to its newest value, or flags a load-use hazard.
module operand_fwd_select
  import alu_operand_forward_unit_pkg::*;
(
  input  logic [REG_AW-1:0] rs_i,
  input  logic              uses_i,
  input  stage_tag_t        ex_tag_i,
  input  stage_tag_t        mem_tag_i,
  input  stage_tag_t        wb_tag_i,
  input  logic [DATA_W-1:0] rf_data_i,
  input  logic [DATA_W-1:0] ex_result_i,
  input  logic [DATA_W-1:0] mem_res_i,
  input  logic [DATA_W-1:0] mem_load_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              hazard_o
);

  fwd_src_e src;
  logic     unused_wb_is_load;

  // WB already holds final data, so its load flag carries no information here.
  assign unused_wb_is_load = wb_tag_i.is_load;

  // Youngest producer wins; a load still in EX has no data yet.
  always_comb begin
    src      = FWD_RF;
    hazard_o = 1'b0;
    if (uses_i) begin
      if (tag_match(ex_tag_i, rs_i)) begin
        src      = FWD_EX;
        hazard_o = ex_tag_i.is_load;
      end else if (tag_match(mem_tag_i, rs_i)) begin
        src = FWD_MEM;
      end else if (tag_match(wb_tag_i, rs_i)) begin
        src = FWD_WB;
      end
    end
  end

  // Data mux for the chosen source; value is discarded when hazard_o stalls the slot.
  always_comb begin
    data_o = rf_data_i;
    case (src)
      FWD_EX:  data_o = ex_result_i;
      FWD_MEM: data_o = mem_tag_i.is_load ? mem_load_i : mem_res_i;
      FWD_WB:  data_o = wb_data_i;
      default: data_o = rf_data_i;
    endcase
  end

endmodule

// File: rtl/alu_operand_forward_unit.sv
// EX-stage operand forwarding, load-use stall and ID/EX operand registers.
module alu_operand_forward_unit
  import alu_operand_forward_unit_pkg::*;
(
  input  logic                       clk_i,
  input  logic                       rst_i,
  alu_operand_forward_unit_if.slave  bus
);

  stage_tag_t        ex_tag_q, ex_tag_d, mem_tag_q, wb_tag_q;
  logic [DATA_W-1:0] mem_res_q, wb_data_q, mem_fwd;
  logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d, res_a, res_b;
  logic              y_sel_q, y_sel_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              haz_a, haz_b, stall;

  assign mem_fwd = mem_tag_q.is_load ? bus.mem_load_data : mem_res_q;

  operand_fwd_select u_sel_a (
    .rs_i(bus.id_rs_a), .uses_i(bus.id_uses_a),
    .ex_tag_i(ex_tag_q), .mem_tag_i(mem_tag_q), .wb_tag_i(wb_tag_q),
    .rf_data_i(bus.rf_data_a), .ex_result_i(bus.ex_result),
    .mem_res_i(mem_res_q), .mem_load_i(bus.mem_load_data), .wb_data_i(wb_data_q),
    .data_o(res_a), .hazard_o(haz_a)
  );

  operand_fwd_select u_sel_b (
    .rs_i(bus.id_rs_b), .uses_i(bus.id_uses_b),
    .ex_tag_i(ex_tag_q), .mem_tag_i(mem_tag_q), .wb_tag_i(wb_tag_q),
    .rf_data_i(bus.rf_data_b), .ex_result_i(bus.ex_result),
    .mem_res_i(mem_res_q), .mem_load_i(bus.mem_load_data), .wb_data_i(wb_data_q),
    .data_o(res_b), .hazard_o(haz_b)
  );

  // Stall decision and next values of the ID/EX boundary; a stall inserts an all-zero bubble.
  always_comb begin
    stall       = bus.id_valid & (haz_a | haz_b);
    ex_tag_d    = '0;
    op_a_d      = '0;
    op_b_d      = '0;
    y_sel_d     = 1'b0;
    stall_cnt_d = stall_cnt_q;
    if (stall) begin
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      ex_tag_d = '{valid: bus.id_valid, rd: bus.id_rd,
                   wr_en: bus.id_wr_en, is_load: bus.id_is_load};
      op_a_d   = res_a;
      op_b_d   = res_b;
      y_sel_d  = bus.id_use_imm;
    end
  end

  // Shadow pipeline and operand registers; MEM and WB keep advancing through a stall.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_tag_q    <= '0;
      mem_tag_q   <= '0;
      wb_tag_q    <= '0;
      mem_res_q   <= '0;
      wb_data_q   <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      y_sel_q     <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      ex_tag_q    <= ex_tag_d;
      mem_tag_q   <= ex_tag_q;
      wb_tag_q    <= mem_tag_q;
      mem_res_q   <= bus.ex_result;
      wb_data_q   <= mem_fwd;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      y_sel_q     <= y_sel_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall       = stall;
  assign bus.ex_valid    = ex_tag_q.valid;
  assign bus.ex_op_a     = op_a_q;
  assign bus.ex_op_b     = op_b_q;
  assign bus.ex_y_sel    = y_sel_q;
  assign bus.stall_count = stall_cnt_q;

endmodule

// File: tb/tb_alu_operand_forward_unit.sv
// Scoreboard bench: driver predicts each edge's outputs from an in-flight instruction model.
module tb_alu_operand_forward_unit;
  import alu_operand_forward_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_operand_forward_unit_if bus();

  alu_operand_forward_unit dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  // One in-flight instruction: slot 0 = EX, 1 = MEM, 2 = WB. val is its known result.
  typedef struct {
    bit        v;
    bit [2:0]  rd;
    bit        wr;
    bit        ld;
    bit [15:0] val;
  } instr_t;

  typedef struct {
    bit        valid;
    bit [15:0] a;
    bit [15:0] b;
    bit        ysel;
    bit [15:0] cnt;
  } exp_t;

  instr_t    pipe[3];
  bit [15:0] rf[8];
  bit [15:0] mcnt;
  exp_t      sbq[$];
  int        vectors = 0;
  int        errors  = 0;
  bit        started = 0;
  bit        done    = 0;

  task automatic check16(string name, logic [15:0] act, logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Newest value of register r in program order, or a hazard if its producer is a load in EX.
  function automatic void resolve(input bit [2:0] r, input bit uses, input bit [15:0] exr,
                                  input bit [15:0] mld, output bit [15:0] v, output bit haz);
    haz = 1'b0;
    v   = rf[r];
    if (!uses || r == 3'd0) return;
    for (int k = 0; k < 3; k++) begin
      if (pipe[k].v && pipe[k].wr && pipe[k].rd == r) begin
        if (k == 0) begin
          if (pipe[k].ld) haz = 1'b1;
          else v = exr;
        end else if (k == 1) begin
          v = pipe[k].ld ? mld : pipe[k].val;
        end else begin
          v = pipe[k].val;
        end
        return;
      end
    end
  endfunction

  // Drive one decode slot (called at a negedge), predict, then step the model across the edge.
  task automatic issue(bit r, bit v, bit [2:0] ra, bit [2:0] rb, bit ua, bit ub,
                       bit [2:0] rd, bit wr, bit ld, bit imm, bit [15:0] exr, bit [15:0] mld);
    exp_t      e;
    bit [15:0] va, vb;
    bit        ha, hb, st;
    rst               = r;
    bus.id_valid      = v;
    bus.id_rs_a       = ra;
    bus.id_rs_b       = rb;
    bus.id_uses_a     = ua;
    bus.id_uses_b     = ub;
    bus.id_rd         = rd;
    bus.id_wr_en      = wr;
    bus.id_is_load    = ld;
    bus.id_use_imm    = imm;
    bus.rf_data_a     = rf[ra];
    bus.rf_data_b     = rf[rb];
    bus.ex_result     = exr;
    bus.mem_load_data = mld;
    resolve(ra, ua, exr, mld, va, ha);
    resolve(rb, ub, exr, mld, vb, hb);
    st = v && (ha || hb);
    #1;
    check16("stall", 16'(bus.stall), 16'(st));
    if (r) begin
      mcnt = 16'h0;
      e    = '{1'b0, 16'h0, 16'h0, 1'b0, 16'h0};
    end else if (st) begin
      if (mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
      e = '{1'b0, 16'h0, 16'h0, 1'b0, mcnt};
    end else begin
      e = '{v, va, vb, imm, mcnt};
    end
    sbq.push_back(e);
    if (r) begin
      for (int k = 0; k < 3; k++) pipe[k] = '{default: 0};
    end else begin
      if (pipe[2].v && pipe[2].wr && pipe[2].rd != 3'd0) rf[pipe[2].rd] = pipe[2].val;
      pipe[2] = pipe[1];
      if (pipe[1].ld) pipe[2].val = mld;
      pipe[1]     = pipe[0];
      pipe[1].val = exr;
      if (st) pipe[0] = '{default: 0};
      else    pipe[0] = '{v, rd, wr, ld, 16'h0};
    end
    started = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(bit r);
    issue(r, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  // Monitor: every edge yields one set of EX-side outputs to compare against the queue head.
  initial begin : monitor
    exp_t e;
    wait (started);
    forever begin
      @(posedge clk);
      #2;
      if (done) break;
      if (sbq.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL sb_empty: got no prediction expected one at %0t", $time);
      end else begin
        e = sbq.pop_front();
        check16("ex_valid", 16'(bus.ex_valid), 16'(e.valid));
        check16("ex_op_a", bus.ex_op_a, e.a);
        check16("ex_op_b", bus.ex_op_b, e.b);
        check16("ex_y_sel", 16'(bus.ex_y_sel), 16'(e.ysel));
        check16("stall_count", bus.stall_count, e.cnt);
      end
    end
  end

  initial begin : driver
    for (int i = 0; i < 8; i++) rf[i] = 16'h0;
    for (int k = 0; k < 3; k++) pipe[k] = '{default: 0};
    mcnt = 16'h0;
    rst  = 1'b1;
    @(negedge clk);
    idle(1'b1);
    idle(1'b1);
    check16("rst_count", bus.stall_count, 16'h0);
    check16("rst_valid", 16'(bus.ex_valid), 16'h0);
    rf[1] = 16'h1111; rf[3] = 16'h3333; rf[5] = 16'h5555; rf[6] = 16'h6666;

    // ALU back-to-back: ADD r1 then SUB reading r1 while ADD sits in EX.
    issue(0, 1, 3'd5, 3'd6, 1, 1, 3'd1, 1, 0, 0, 16'h0BAD, 16'h0);
    issue(0, 1, 3'd1, 3'd6, 1, 1, 3'd7, 1, 0, 0, 16'h1234, 16'h0);
    check16("b2b_op_a", bus.ex_op_a, 16'h1234);

    // Load-use: LD r2, ADD reading r2 stalls once then takes the load data from MEM.
    issue(0, 1, 3'd0, 3'd0, 0, 0, 3'd2, 1, 1, 1, 16'h0, 16'h0);
    issue(0, 1, 3'd3, 3'd2, 1, 1, 3'd4, 1, 0, 0, 16'hAAAA, 16'h0);
    check16("lu_bubble", 16'(bus.ex_valid), 16'h0);
    issue(0, 1, 3'd3, 3'd2, 1, 1, 3'd4, 1, 0, 0, 16'h0, 16'hBEEF);
    check16("lu_op_b", bus.ex_op_b, 16'hBEEF);
    check16("lu_count", bus.stall_count, 16'h1);

    // Priority: r3 written by WB, MEM and EX; EX wins.
    issue(0, 1, 3'd0, 3'd0, 0, 0, 3'd3, 1, 0, 0, 16'h0, 16'h0);
    issue(0, 1, 3'd0, 3'd0, 0, 0, 3'd3, 1, 0, 0, 16'h0001, 16'h0);
    issue(0, 1, 3'd0, 3'd0, 0, 0, 3'd3, 1, 0, 0, 16'h0002, 16'h0);
    issue(0, 1, 3'd3, 3'd3, 1, 1, 3'd7, 1, 0, 0, 16'h0003, 16'h0);
    check16("prio_op_a", bus.ex_op_a, 16'h0003);
    check16("prio_op_b", bus.ex_op_b, 16'h0003);

    // r0 and immediate: an EX write to r0 must not forward.
    issue(0, 1, 3'd0, 3'd0, 0, 0, 3'd0, 1, 0, 0, 16'h0, 16'h0);
    issue(0, 1, 3'd0, 3'd1, 1, 0, 3'd7, 1, 0, 1, 16'hFFFF, 16'h0);
    check16("r0_op_a", bus.ex_op_a, 16'h0000);
    check16("r0_y_sel", 16'(bus.ex_y_sel), 16'h1);

    // WB forward with a stale register file.
    rf[4] = 16'h0000;
    issue(0, 1, 3'd0, 3'd0, 0, 0, 3'd4, 1, 0, 0, 16'h0, 16'h0);
    issue(0, 1, 3'd0, 3'd0, 0, 0, 3'd0, 0, 0, 0, 16'h5A5A, 16'h0);
    issue(0, 1, 3'd0, 3'd0, 0, 0, 3'd0, 0, 0, 0, 16'h0, 16'h0);
    issue(0, 1, 3'd4, 3'd0, 1, 0, 3'd7, 0, 0, 0, 16'h0, 16'h0);
    check16("wb_op_a", bus.ex_op_a, 16'h5A5A);

    // Reset asserted in the stall cycle.
    issue(0, 1, 3'd0, 3'd0, 0, 0, 3'd5, 1, 1, 0, 16'h0, 16'h0);
    issue(1, 1, 3'd5, 3'd0, 1, 0, 3'd6, 1, 0, 0, 16'h0, 16'h0);
    #1;
    check16("rst_stall_drop", 16'(bus.stall), 16'h0);
    check16("rst_mid_count", bus.stall_count, 16'h0);
    check16("rst_mid_op_a", bus.ex_op_a, 16'h0);
    idle(1'b0);

    // Saturation: preload near the top and stall twice.
    force dut.stall_cnt_q = 16'hFFFE;
    #1;
    release dut.stall_cnt_q;
    mcnt = 16'hFFFE;
    for (int n = 0; n < 2; n++) begin
      issue(0, 1, 3'd0, 3'd0, 0, 0, 3'd6, 1, 1, 0, 16'h0, 16'h0);
      issue(0, 1, 3'd6, 3'd6, 1, 1, 3'd7, 1, 0, 0, 16'h0, 16'h0);
      check16("sat_count", bus.stall_count, 16'hFFFF);
      idle(1'b0);
    end

    // Randomized traffic over a narrow register range to provoke hazards and forwards.
    for (int n = 0; n < 500; n++) begin
      bit v;
      v = ($urandom_range(0, 3) != 0);
      issue(0, v, 3'($urandom_range(0, 4)), 3'($urandom_range(0, 4)),
            v & 1'($urandom), v & 1'($urandom), 3'($urandom_range(0, 4)),
            1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom),
            16'($urandom), 16'($urandom));
    end
    idle(1'b0);

    done = 1'b1;
    if (sbq.size() != 0) begin
      vectors++;
      errors++;
      $display("FAIL sb_leftover: got %0d entries expected 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
